rat_cu_irq: RTL and testbench
=============================

# rat_cu_irq

Multi-cycle control unit for the RAT CPU, successor to the single-cycle FETCH/EXEC controller. It decodes the 7-bit opcode into datapath strobes and adds interrupt entry, stack and scratch-RAM instructions (CALL/RET/PUSH/POP/LD/ST), an internal interrupt-enable flag and a parametrised scratch-RAM read latency. It sits between the program ROM output and the PC, register file, ALU, flags, SP and scratch RAM in the CPU top level.

## Interface
- MEM_WAIT, 0, extra EXEC cycles for scratch-RAM reads (0..3)
- IRQ_SYNC, 2, interrupt synchronizer flops (1..3)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- c, z  in  1 each  current C/Z flags
- interrupt  in  1  asynchronous level interrupt request
- opcode  in  7  {ir[17:13], ir[1:0]}
- pc_ld, pc_inc  out  1  PC load/increment
- pc_mux_sel  out  2  0 immediate, 1 scratch data (return), 2 vector 0x3FF
- rf_wr  out  1  register-file write
- rf_wr_sel  out  2  0 ALU, 1 scratch, 2 SP, 3 IN port
- alu_opy_sel  out  1  0 register, 1 immediate
- alu_sel  out  4  ALU function
- sp_ld, sp_incr, sp_decr  out  1 each  stack-pointer controls
- scr_we  out  1  scratch-RAM write
- scr_addr_sel  out  2  0 Ry, 1 immediate, 2 SP, 3 SP-1
- scr_data_sel  out  1  0 Rx, 1 PC
- flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld, flg_ld_sel, flg_shad_ld  out  1 each  flag controls
- io_strb  out  1  output-port strobe
- i_flag  out  1  interrupt enable
- rst  out  1  datapath reset

## Operation
- States: INIT, FETCH, EXEC, WAIT, INTR. reset -> INIT. INIT: rst=1 -> FETCH. FETCH: pc_inc=1 -> EXEC.
- EXEC -> WAIT if opcode is a read (LD, POP, RET, RETID, RETIE) and MEM_WAIT>0; else -> INTR if irq_s && i_flag; else -> FETCH.
- WAIT: counter from MEM_WAIT-1 to 0; scr_addr_sel held; at 0 -> INTR/FETCH per same rule.
- INTR: pc_ld=1, pc_mux_sel=2, scr_we=1, scr_addr_sel=3, scr_data_sel=1, sp_decr=1, flg_shad_ld=1, i_flag cleared -> FETCH.
- All outputs default 0 every state. Read instructions assert their write strobes (rf_wr, pc_ld, sp_incr, flag restore) only in the final execute cycle (EXEC when MEM_WAIT=0, last WAIT otherwise).
- ALU reg/reg 0000000-0001001 and imm 10000xx-11011xx: alu_sel AND5 OR6 EXOR7 TEST8 ADD0 ADDC1 SUB2 SUBC3 CMP4 MOV14; alu_opy_sel=1 for imm; rf_wr=1, rf_wr_sel=0 except TEST/CMP; logic ops flg_c_clr+flg_z_ld; arithmetic/CMP flg_c_ld+flg_z_ld; MOV no flags.
- Shifts 01000xx, 0100100: alu_sel 9..13, rf_wr, flg_c_ld, flg_z_ld. IN 11001xx: rf_wr, sel 3. OUT 11010xx: io_strb.
- Branches BRN 0010000, BREQ 0010010 (z), BRNE 0010011 (!z), BRCS 0010100 (c), BRCC 0010101 (!c): pc_ld, sel 0 when taken.
- CALL 0010001: pc_ld, scr_we, addr 3, data 1, sp_decr. RET 0110010: pc_ld, sel 1, addr 2, sp_incr.
- RETID 0110110/RETIE 0110111: as RET plus flg_ld_sel=1, flg_c_ld, flg_z_ld; i_flag <= 0/1.
- PUSH 0100101: scr_we, addr 3, sp_decr. POP 0100110: rf_wr, sel 1, addr 2, sp_incr.
- LD 0001010/11100xx: rf_wr, sel 1, addr 0/1. ST 0001011/11101xx: scr_we, addr 0/1.
- WSP 0101000: sp_ld. RSP 0101001: rf_wr, sel 2. CLC 0110000, SEC 0110001, SEI 0110100 (i_flag<=1), CLI 0110101 (i_flag<=0).
- Undefined opcodes: no strobes, -> FETCH.

## Timing
- Reset: state INIT, i_flag=0, synchronizer and wait counter 0; all outputs 0 except rst=1 in the INIT cycle.
- Non-read instruction: 2 cycles; read: 2+MEM_WAIT; interrupt adds 1 INTR cycle.
- interrupt seen IRQ_SYNC cycles after assertion; sampled only at end of final execute cycle.
- SEI/RETIE in EXEC: i_flag is 1 the next cycle, so interrupt entry from the same instruction's final cycle uses the old value (0); entry occurs after the next instruction.
- reset mid-WAIT or INTR: abort, no further strobes, INIT next cycle.

## Test plan
- Reset held 3 cycles -> rst=1 in INIT, pc_inc=1 next cycle, i_flag=0, all else 0.
- opcode 0010010 with z=1 -> pc_ld=1, pc_mux_sel=0 in EXEC; z=0 -> pc_ld=0.
- MEM_WAIT=2, POP 0100110 -> EXEC+2 WAIT cycles, rf_wr/sp_incr only in last WAIT cycle, scr_addr_sel=2 throughout.
- SEI then interrupt held high, IRQ_SYNC=2 -> INTR after following instruction: pc_mux_sel=2, scr_we, sp_decr, flg_shad_ld; i_flag=0 after.
- RETIE 0110111 -> pc_mux_sel=1, flg_ld_sel=1, sp_incr; i_flag=1 next cycle.
- reset asserted in WAIT of LD -> rf_wr never pulses; INIT next cycle.

Source files
------------

// File: rtl/rat_cu_irq.sv
// RAT CPU multi-cycle control unit: opcode decode, stack/scratch-RAM sequencing,
// scratch-read wait states and interrupt entry with a synchronized request.
module rat_cu_irq #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IRQ_SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c,
    input  logic       z,
    input  logic       interrupt,
    input  logic [6:0] opcode,
    output logic       pc_ld,
    output logic       pc_inc,
    output logic [1:0] pc_mux_sel,
    output logic       rf_wr,
    output logic [1:0] rf_wr_sel,
    output logic       alu_opy_sel,
    output logic [3:0] alu_sel,
    output logic       sp_ld,
    output logic       sp_incr,
    output logic       sp_decr,
    output logic       scr_we,
    output logic [1:0] scr_addr_sel,
    output logic       scr_data_sel,
    output logic       flg_c_set,
    output logic       flg_c_clr,
    output logic       flg_c_ld,
    output logic       flg_z_ld,
    output logic       flg_ld_sel,
    output logic       flg_shad_ld,
    output logic       io_strb,
    output logic       i_flag,
    output logic       rst
);

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned WAIT_INIT = (MEM_WAIT != 0) ? MEM_WAIT - 1 : 0;
    localparam bit          HAS_WAIT  = (MEM_WAIT != 0);

    typedef enum logic [2:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WAIT, ST_INTR} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [IRQ_SYNC-1:0] irq_sync;
    logic                irq_s;
    logic                fin, i_set, i_clr;

    logic       d_pc_ld, d_rf_wr, d_alu_opy_sel, d_sp_ld, d_sp_incr, d_sp_decr;
    logic       d_scr_we, d_scr_data_sel, d_flg_c_set, d_flg_c_clr, d_flg_c_ld;
    logic       d_flg_z_ld, d_flg_ld_sel, d_io_strb, d_i_set, d_i_clr, is_read;
    logic [1:0] d_pc_mux_sel, d_rf_wr_sel, d_scr_addr_sel;
    logic [3:0] d_alu_sel, alu_k;
    logic       alu_hit, alu_imm;

    assign irq_s = irq_sync[IRQ_SYNC-1];

    // Opcode decode, independent of sequencing state
    always_comb begin
        d_pc_ld = 1'b0;  d_pc_mux_sel = 2'd0;  d_rf_wr = 1'b0;  d_rf_wr_sel = 2'd0;
        d_alu_opy_sel = 1'b0;  d_alu_sel = 4'd0;  d_sp_ld = 1'b0;  d_sp_incr = 1'b0;
        d_sp_decr = 1'b0;  d_scr_we = 1'b0;  d_scr_addr_sel = 2'd0;  d_scr_data_sel = 1'b0;
        d_flg_c_set = 1'b0;  d_flg_c_clr = 1'b0;  d_flg_c_ld = 1'b0;  d_flg_z_ld = 1'b0;
        d_flg_ld_sel = 1'b0;  d_io_strb = 1'b0;  d_i_set = 1'b0;  d_i_clr = 1'b0;
        is_read = 1'b0;  alu_hit = 1'b0;  alu_imm = 1'b0;  alu_k = 4'd0;

        // ALU index 0..9: AND OR EXOR TEST ADD ADDC SUB SUBC CMP MOV
        if (opcode[6:4] == 3'b000 && opcode[3:0] <= 4'd9) begin
            alu_hit = 1'b1;
            alu_k   = opcode[3:0];
        end else if (opcode[6] && opcode[6:2] <= 5'b11000) begin
            alu_hit = 1'b1;
            alu_imm = 1'b1;
            alu_k   = 4'(opcode[6:2] - 5'd16);
        end else if (opcode[6:2] == 5'b11011) begin
            alu_hit = 1'b1;
            alu_imm = 1'b1;
            alu_k   = 4'd9;
        end

        casez (opcode)
            7'b01000??: begin
                d_alu_sel = 4'd9 + {2'b00, opcode[1:0]};
                d_rf_wr = 1'b1;  d_flg_c_ld = 1'b1;  d_flg_z_ld = 1'b1;
            end
            7'b0100100: begin
                d_alu_sel = 4'd13;
                d_rf_wr = 1'b1;  d_flg_c_ld = 1'b1;  d_flg_z_ld = 1'b1;
            end
            7'b11001??: begin d_rf_wr = 1'b1; d_rf_wr_sel = 2'd3; end
            7'b11010??: d_io_strb = 1'b1;
            7'b0010000: d_pc_ld = 1'b1;
            7'b0010010: d_pc_ld = z;
            7'b0010011: d_pc_ld = ~z;
            7'b0010100: d_pc_ld = c;
            7'b0010101: d_pc_ld = ~c;
            7'b0010001: begin
                d_pc_ld = 1'b1;  d_scr_we = 1'b1;  d_scr_addr_sel = 2'd3;
                d_scr_data_sel = 1'b1;  d_sp_decr = 1'b1;
            end
            7'b0110010, 7'b0110110, 7'b0110111: begin
                is_read = 1'b1;  d_pc_ld = 1'b1;  d_pc_mux_sel = 2'd1;
                d_scr_addr_sel = 2'd2;  d_sp_incr = 1'b1;
                if (opcode[2]) begin
                    d_flg_ld_sel = 1'b1;  d_flg_c_ld = 1'b1;  d_flg_z_ld = 1'b1;
                    d_i_set = opcode[0];  d_i_clr = ~opcode[0];
                end
            end
            7'b0100101: begin d_scr_we = 1'b1; d_scr_addr_sel = 2'd3; d_sp_decr = 1'b1; end
            7'b0100110: begin
                is_read = 1'b1;  d_rf_wr = 1'b1;  d_rf_wr_sel = 2'd1;
                d_scr_addr_sel = 2'd2;  d_sp_incr = 1'b1;
            end
            7'b0001010: begin is_read = 1'b1; d_rf_wr = 1'b1; d_rf_wr_sel = 2'd1; end
            7'b11100??: begin
                is_read = 1'b1;  d_rf_wr = 1'b1;  d_rf_wr_sel = 2'd1;  d_scr_addr_sel = 2'd1;
            end
            7'b0001011: d_scr_we = 1'b1;
            7'b11101??: begin d_scr_we = 1'b1; d_scr_addr_sel = 2'd1; end
            7'b0101000: d_sp_ld = 1'b1;
            7'b0101001: begin d_rf_wr = 1'b1; d_rf_wr_sel = 2'd2; end
            7'b0110000: d_flg_c_clr = 1'b1;
            7'b0110001: d_flg_c_set = 1'b1;
            7'b0110100: d_i_set = 1'b1;
            7'b0110101: d_i_clr = 1'b1;
            default: begin
                if (alu_hit) begin
                    d_alu_opy_sel = alu_imm;
                    d_rf_wr = (alu_k != 4'd3) && (alu_k != 4'd8);
                    if (alu_k <= 4'd3) begin
                        d_flg_c_clr = 1'b1;  d_flg_z_ld = 1'b1;
                    end else if (alu_k <= 4'd8) begin
                        d_flg_c_ld = 1'b1;  d_flg_z_ld = 1'b1;
                    end
                    case (alu_k)
                        4'd0:    d_alu_sel = 4'd5;
                        4'd1:    d_alu_sel = 4'd6;
                        4'd2:    d_alu_sel = 4'd7;
                        4'd3:    d_alu_sel = 4'd8;
                        4'd4:    d_alu_sel = 4'd0;
                        4'd5:    d_alu_sel = 4'd1;
                        4'd6:    d_alu_sel = 4'd2;
                        4'd7:    d_alu_sel = 4'd3;
                        4'd8:    d_alu_sel = 4'd4;
                        default: d_alu_sel = 4'd14;
                    endcase
                end
            end
        endcase
    end

    // Next state and strobes; write strobes only in the final execute cycle
    always_comb begin
        state_nx = state;
        pc_ld = 1'b0;  pc_inc = 1'b0;  pc_mux_sel = 2'd0;  rf_wr = 1'b0;  rf_wr_sel = 2'd0;
        alu_opy_sel = 1'b0;  alu_sel = 4'd0;  sp_ld = 1'b0;  sp_incr = 1'b0;  sp_decr = 1'b0;
        scr_we = 1'b0;  scr_addr_sel = 2'd0;  scr_data_sel = 1'b0;  flg_c_set = 1'b0;
        flg_c_clr = 1'b0;  flg_c_ld = 1'b0;  flg_z_ld = 1'b0;  flg_ld_sel = 1'b0;
        flg_shad_ld = 1'b0;  io_strb = 1'b0;  fin = 1'b0;  i_set = 1'b0;  i_clr = 1'b0;
        rst = (state == ST_INIT);

        if (!reset) begin
            case (state)
                ST_INIT:  state_nx = ST_FETCH;
                ST_FETCH: begin
                    pc_inc   = 1'b1;
                    state_nx = ST_EXEC;
                end
                ST_EXEC, ST_WAIT: begin
                    pc_mux_sel   = d_pc_mux_sel;
                    rf_wr_sel    = d_rf_wr_sel;
                    alu_opy_sel  = d_alu_opy_sel;
                    alu_sel      = d_alu_sel;
                    scr_addr_sel = d_scr_addr_sel;
                    scr_data_sel = d_scr_data_sel;
                    flg_ld_sel   = d_flg_ld_sel;
                    fin = (state == ST_WAIT) ? (cnt == '0) : !(is_read && HAS_WAIT);
                    if (fin) begin
                        pc_ld = d_pc_ld;  rf_wr = d_rf_wr;  sp_ld = d_sp_ld;
                        sp_incr = d_sp_incr;  sp_decr = d_sp_decr;  scr_we = d_scr_we;
                        flg_c_set = d_flg_c_set;  flg_c_clr = d_flg_c_clr;
                        flg_c_ld = d_flg_c_ld;  flg_z_ld = d_flg_z_ld;  io_strb = d_io_strb;
                        i_set = d_i_set;  i_clr = d_i_clr;
                        state_nx = (irq_s && i_flag) ? ST_INTR : ST_FETCH;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
                ST_INTR: begin
                    pc_ld = 1'b1;  pc_mux_sel = 2'd2;  scr_we = 1'b1;  scr_addr_sel = 2'd3;
                    scr_data_sel = 1'b1;  sp_decr = 1'b1;  flg_shad_ld = 1'b1;
                    i_clr = 1'b1;
                    state_nx = ST_FETCH;
                end
                default: state_nx = ST_INIT;
            endcase
        end
    end

    // State, wait counter, interrupt enable and request synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            cnt      <= '0;
            i_flag   <= 1'b0;
            irq_sync <= '0;
        end else begin
            state       <= state_nx;
            irq_sync[0] <= interrupt;
            for (int unsigned i = 1; i < IRQ_SYNC; i++) begin
                irq_sync[i] <= irq_sync[i-1];
            end
            if (state == ST_EXEC) begin
                cnt <= CNT_W'(WAIT_INIT);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (i_clr) begin
                i_flag <= 1'b0;
            end else if (i_set) begin
                i_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rat_cu_irq.sv
// Directed bench for rat_cu_irq with two scratch-read wait states and a
// two-flop interrupt synchronizer.
module tb_rat_cu_irq;

    logic       clk = 1'b0;
    logic       reset, c, z, interrupt;
    logic [6:0] opcode;
    logic       pc_ld, pc_inc, rf_wr, alu_opy_sel, sp_ld, sp_incr, sp_decr, scr_we;
    logic       scr_data_sel, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld, flg_ld_sel;
    logic       flg_shad_ld, io_strb, i_flag, rst;
    logic [1:0] pc_mux_sel, rf_wr_sel, scr_addr_sel;
    logic [3:0] alu_sel;
    logic [25:0] all_outs;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rat_cu_irq #(.MEM_WAIT(2), .IRQ_SYNC(2)) dut (
        .clk(clk), .reset(reset), .c(c), .z(z), .interrupt(interrupt), .opcode(opcode),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_mux_sel(pc_mux_sel), .rf_wr(rf_wr),
        .rf_wr_sel(rf_wr_sel), .alu_opy_sel(alu_opy_sel), .alu_sel(alu_sel),
        .sp_ld(sp_ld), .sp_incr(sp_incr), .sp_decr(sp_decr), .scr_we(scr_we),
        .scr_addr_sel(scr_addr_sel), .scr_data_sel(scr_data_sel),
        .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_c_ld(flg_c_ld),
        .flg_z_ld(flg_z_ld), .flg_ld_sel(flg_ld_sel), .flg_shad_ld(flg_shad_ld),
        .io_strb(io_strb), .i_flag(i_flag), .rst(rst)
    );

    assign all_outs = {pc_ld, pc_inc, pc_mux_sel, rf_wr, rf_wr_sel, alu_opy_sel, alu_sel,
                       sp_ld, sp_incr, sp_decr, scr_we, scr_addr_sel, scr_data_sel,
                       flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld, flg_ld_sel, flg_shad_ld,
                       io_strb};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait through FETCH (checking pc_inc), present op, stop mid-EXEC
    task automatic go_exec(input logic [6:0] op);
        @(negedge clk); #1;
        chk("fetch_pc_inc", 32'(pc_inc), 32'd1);
        opcode = op;
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;  c = 1'b0;  z = 1'b0;  interrupt = 1'b0;  opcode = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0; #1;
        chk("init_rst", 32'(rst), 32'd1);
        chk("init_outs", 32'(all_outs), 32'd0);
        chk("init_iflag", 32'(i_flag), 32'd0);

        // BREQ taken then not taken
        z = 1'b1;
        go_exec(7'b0010010);
        chk("init_rst_low", 32'(rst), 32'd0);
        chk("breq_t_ld", 32'(pc_ld), 32'd1);
        chk("breq_t_sel", 32'(pc_mux_sel), 32'd0);
        chk("breq_t_inc", 32'(pc_inc), 32'd0);
        z = 1'b0;
        go_exec(7'b0010010);
        chk("breq_nt_ld", 32'(pc_ld), 32'd0);

        // ALU forms
        go_exec(7'b0000100);
        chk("add_sel", 32'(alu_sel), 32'd0);
        chk("add_flags", 32'({rf_wr, alu_opy_sel, flg_c_ld, flg_z_ld, flg_c_clr}), 32'b10110);
        go_exec(7'b1000011);
        chk("andi_sel", 32'(alu_sel), 32'd5);
        chk("andi_flags", 32'({rf_wr, alu_opy_sel, flg_c_ld, flg_z_ld, flg_c_clr}), 32'b11011);
        go_exec(7'b0001000);
        chk("cmp_sel", 32'(alu_sel), 32'd4);
        chk("cmp_nowr", 32'(rf_wr), 32'd0);

        // POP with two wait states
        go_exec(7'b0100110);
        chk("pop_e_addr", 32'(scr_addr_sel), 32'd2);
        chk("pop_e_wr", 32'({rf_wr, sp_incr}), 32'd0);
        @(negedge clk); #1;
        chk("pop_w1_addr", 32'(scr_addr_sel), 32'd2);
        chk("pop_w1_wr", 32'({rf_wr, sp_incr, pc_inc}), 32'd0);
        @(negedge clk); #1;
        chk("pop_w2_addr", 32'(scr_addr_sel), 32'd2);
        chk("pop_w2_wr", 32'({rf_wr, rf_wr_sel, sp_incr}), 32'b1011);

        // CALL; raise interrupt so it is already synchronized during SEI
        go_exec(7'b0010001);
        chk("call", 32'({pc_ld, scr_we, scr_addr_sel, scr_data_sel, sp_decr}), 32'b111111);
        interrupt = 1'b1;
        go_exec(7'b0110100);
        chk("sei_iflag_old", 32'(i_flag), 32'd0);
        go_exec(7'b0110000);
        chk("clc_iflag", 32'(i_flag), 32'd1);
        chk("clc_clr", 32'(flg_c_clr), 32'd1);
        @(negedge clk); #1;
        chk("intr_pc", 32'({pc_ld, pc_mux_sel, pc_inc}), 32'b1100);
        chk("intr_stk", 32'({scr_we, scr_addr_sel, scr_data_sel, sp_decr, flg_shad_ld}), 32'b111111);
        interrupt = 1'b0;

        // RETIE restores flags and re-enables interrupts after its last cycle
        go_exec(7'b0110111);
        chk("intr_iflag_clr", 32'(i_flag), 32'd0);
        chk("retie_e", 32'({pc_ld, pc_mux_sel, flg_ld_sel, scr_addr_sel}), 32'b001110);
        @(negedge clk); #1;
        chk("retie_w1", 32'({pc_ld, sp_incr, flg_c_ld}), 32'd0);
        @(negedge clk); #1;
        chk("retie_w2", 32'({pc_ld, pc_mux_sel, flg_ld_sel, sp_incr, flg_c_ld, flg_z_ld}), 32'b1011111);
        chk("retie_w2_iflag", 32'(i_flag), 32'd0);
        go_exec(7'b0110101);
        chk("retie_iflag_set", 32'(i_flag), 32'd1);
        go_exec(7'b1101000);
        chk("cli_iflag", 32'(i_flag), 32'd0);
        chk("out_strb", 32'(io_strb), 32'd1);

        // LD immediate aborted by reset in its final wait cycle
        go_exec(7'b1110001);
        chk("ld_e", 32'({rf_wr, scr_addr_sel, rf_wr_sel}), 32'b00101);
        @(negedge clk); #1;
        chk("ld_w1_wr", 32'(rf_wr), 32'd0);
        @(negedge clk);
        reset = 1'b1; #1;
        chk("ld_abort_outs", 32'(all_outs), 32'd0);
        @(negedge clk); #1;
        chk("ld_abort_init", 32'(rst), 32'd1);
        chk("ld_abort_wr", 32'(rf_wr), 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("after_reset_fetch", 32'({pc_inc, rst}), 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
